mem_access_unit: RTL and testbench

- Request/response front end that sits directly upstream of the word-addressed synchronous data memory (Mem) in the MIPS datapath.
- Accepts byte-addressed CPU load/store requests of byte, halfword or word size and drives the memory's sel/str/ld/clr/addr/data_in pins.
- Performs big-endian lane extraction with sign/zero extension for loads, and read-modify-write for sub-word stores.
- Returns one response per request over a valid/ready handshake.

---
 rtl/mem_access_pkg.sv | 42 ++++
 rtl/mem_access_unit_if.sv | 38 +++
 rtl/mem_lane_fmt.sv | 66 ++++++
 rtl/mem_access_unit.sv | 147 ++++++++++++++
 tb/tb_mem_access_unit.sv | 257 +++++++++++++++++++++++++
 5 files changed

// File: rtl/mem_access_pkg.sv
// Shared types for mem_access_unit: FSM states, access size codes and memory pin commands.
package mem_access_pkg;

    localparam int unsigned DATA_BITS = 32;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_RD,
        ST_RD_WAIT,
        ST_WR,
        ST_FLUSH,
        ST_RESP
    } state_e;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;
    localparam logic [1:0] SZ_ILL  = 2'b11;

    typedef struct packed {
        logic sel;
        logic str;
        logic ld;
        logic clr;
    } mem_cmd_t;

    localparam mem_cmd_t CMD_IDLE  = 4'b0000;
    localparam mem_cmd_t CMD_READ  = 4'b1010;
    localparam mem_cmd_t CMD_WRITE = 4'b1100;
    localparam mem_cmd_t CMD_CLEAR = 4'b0001;

    // Memory pins implied by the state the FSM is entering.
    function automatic mem_cmd_t cmd_for(input state_e s);
        case (s)
            ST_RD:    return CMD_READ;
            ST_WR:    return CMD_WRITE;
            ST_FLUSH: return CMD_CLEAR;
            default:  return CMD_IDLE;
        endcase
    endfunction

endpackage

// File: rtl/mem_access_unit_if.sv
// CPU request/response handshake plus data-memory pins for mem_access_unit.
interface mem_access_unit_if import mem_access_pkg::*; #(
    parameter int unsigned ADDR_BITS = 10
);
    logic                   req_valid;
    logic                   req_ready;
    logic                   req_we;
    logic [1:0]             req_size;
    logic                   req_signed;
    logic [ADDR_BITS+1:0]   req_addr;
    logic [DATA_BITS-1:0]   req_wdata;
    logic                   flush_req;
    logic                   resp_valid;
    logic                   resp_ready;
    logic [DATA_BITS-1:0]   resp_rdata;
    logic                   resp_err;
    logic [ADDR_BITS-1:0]   mem_addr;
    logic [DATA_BITS-1:0]   mem_din;
    logic [DATA_BITS-1:0]   mem_dout;
    logic                   mem_sel;
    logic                   mem_str;
    logic                   mem_ld;
    logic                   mem_clr;

    modport slave (
        input  req_valid, req_we, req_size, req_signed, req_addr, req_wdata,
               flush_req, resp_ready, mem_dout,
        output req_ready, resp_valid, resp_rdata, resp_err,
               mem_addr, mem_din, mem_sel, mem_str, mem_ld, mem_clr
    );

    modport master (
        output req_valid, req_we, req_size, req_signed, req_addr, req_wdata,
               flush_req, resp_ready, mem_dout,
        input  req_ready, resp_valid, resp_rdata, resp_err,
               mem_addr, mem_din, mem_sel, mem_str, mem_ld, mem_clr
    );
endinterface

// File: rtl/mem_lane_fmt.sv
// Big-endian lane extract/extend for loads, lane merge for sub-word stores, alignment check.
// MEM_ACCESS_ALIGN_CHECK_EN: flag misaligned half/word accesses instead of forcing alignment.
module mem_lane_fmt import mem_access_pkg::*; (
    input  logic [1:0]           size,
    input  logic                 sgn,
    input  logic [1:0]           off,
    input  logic [DATA_BITS-1:0] rd_word,
    input  logic [15:0]          wdata,
    output logic [DATA_BITS-1:0] ld_data_c,
    output logic [DATA_BITS-1:0] merged_c,
    output logic                 err_c
);
    logic [1:0]  off_c;
    logic [7:0]  byte_c;
    logic [15:0] half_c;

    always_comb begin
        // Low offset bits below the access size never select a lane.
        off_c = off;
        if (size == SZ_HALF) begin
            off_c[0] = 1'b0;
        end else if (size != SZ_BYTE) begin
            off_c = 2'b00;
        end

`ifdef MEM_ACCESS_ALIGN_CHECK_EN
        err_c = (size == SZ_ILL) ||
                ((size == SZ_HALF) && off[0]) ||
                ((size == SZ_WORD) && (off != 2'b00));
`else
        err_c = (size == SZ_ILL);
`endif

        case (off_c)
            2'd0:    byte_c = rd_word[31:24];
            2'd1:    byte_c = rd_word[23:16];
            2'd2:    byte_c = rd_word[15:8];
            default: byte_c = rd_word[7:0];
        endcase
        half_c = off_c[1] ? rd_word[15:0] : rd_word[31:16];

        ld_data_c = rd_word;
        merged_c  = rd_word;
        case (size)
            SZ_BYTE: begin
                ld_data_c = {{24{sgn & byte_c[7]}}, byte_c};
                case (off_c)
                    2'd0:    merged_c[31:24] = wdata[7:0];
                    2'd1:    merged_c[23:16] = wdata[7:0];
                    2'd2:    merged_c[15:8]  = wdata[7:0];
                    default: merged_c[7:0]   = wdata[7:0];
                endcase
            end
            SZ_HALF: begin
                ld_data_c = {{16{sgn & half_c[15]}}, half_c};
                if (off_c[1]) begin
                    merged_c[15:0] = wdata;
                end else begin
                    merged_c[31:16] = wdata;
                end
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/mem_access_unit.sv
// Byte/half/word load-store front end for a word-addressed synchronous memory.
// MEM_ACCESS_ALIGN_CHECK_EN selects error reporting for misaligned accesses (see mem_lane_fmt).
module mem_access_unit import mem_access_pkg::*; #(
    parameter int unsigned ADDR_BITS = 10
) (
    input  logic              clk,
    input  logic              clr_n,
    mem_access_unit_if.slave  bus
);
    state_e                 state_q, state_d;
    logic                   we_q, we_d;
    logic                   sgn_q, sgn_d;
    logic [1:0]             size_q, size_d;
    logic [1:0]             off_q, off_d;
    logic [15:0]            wdata_q, wdata_d;
    logic [ADDR_BITS-1:0]   mem_addr_q, mem_addr_d;
    logic [DATA_BITS-1:0]   mem_din_q, mem_din_d;
    mem_cmd_t               cmd_q, cmd_d;
    logic                   req_ready_q, req_ready_d;
    logic                   resp_valid_q, resp_valid_d;
    logic                   resp_err_q, resp_err_d;
    logic [DATA_BITS-1:0]   resp_rdata_q, resp_rdata_d;

    logic [1:0]             fmt_size_c, fmt_off_c;
    logic [DATA_BITS-1:0]   ld_data_c, merged_c;
    logic                   err_c;

    // In IDLE the formatter classifies the live request; afterwards it works on the latched one.
    assign fmt_size_c = (state_q == ST_IDLE) ? bus.req_size     : size_q;
    assign fmt_off_c  = (state_q == ST_IDLE) ? bus.req_addr[1:0] : off_q;

    mem_lane_fmt u_fmt (
        .size      (fmt_size_c),
        .sgn       (sgn_q),
        .off       (fmt_off_c),
        .rd_word   (bus.mem_dout),
        .wdata     (wdata_q),
        .ld_data_c (ld_data_c),
        .merged_c  (merged_c),
        .err_c     (err_c)
    );

    always_comb begin
        state_d      = state_q;
        we_d         = we_q;
        sgn_d        = sgn_q;
        size_d       = size_q;
        off_d        = off_q;
        wdata_d      = wdata_q;
        mem_addr_d   = mem_addr_q;
        mem_din_d    = mem_din_q;
        resp_err_d   = resp_err_q;
        resp_rdata_d = resp_rdata_q;

        case (state_q)
            ST_IDLE: begin
                if (bus.flush_req) begin
                    state_d = ST_FLUSH;
                end else if (bus.req_valid) begin
                    we_d         = bus.req_we;
                    sgn_d        = bus.req_signed;
                    size_d       = bus.req_size;
                    off_d        = bus.req_addr[1:0];
                    wdata_d      = bus.req_wdata[15:0];
                    mem_addr_d   = bus.req_addr[ADDR_BITS+1:2];
                    resp_err_d   = err_c;
                    resp_rdata_d = '0;
                    if (err_c) begin
                        state_d = ST_RESP;
                    end else if (bus.req_we && (bus.req_size == SZ_WORD)) begin
                        mem_din_d = bus.req_wdata;
                        state_d   = ST_WR;
                    end else begin
                        state_d = ST_RD;
                    end
                end
            end
            ST_RD:      state_d = ST_RD_WAIT;
            ST_RD_WAIT: begin
                if (we_q) begin
                    mem_din_d = merged_c;
                    state_d   = ST_WR;
                end else begin
                    resp_rdata_d = ld_data_c;
                    state_d      = ST_RESP;
                end
            end
            ST_WR:      state_d = ST_RESP;
            ST_FLUSH:   state_d = ST_IDLE;
            ST_RESP: begin
                if (bus.resp_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default:    state_d = ST_IDLE;
        endcase

        // Outputs are registered from the state being entered.
        cmd_d        = cmd_for(state_d);
        req_ready_d  = (state_d == ST_IDLE);
        resp_valid_d = (state_d == ST_RESP);
    end

    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            state_q      <= ST_IDLE;
            we_q         <= 1'b0;
            sgn_q        <= 1'b0;
            size_q       <= SZ_BYTE;
            off_q        <= 2'b00;
            wdata_q      <= '0;
            mem_addr_q   <= '0;
            mem_din_q    <= '0;
            cmd_q        <= CMD_IDLE;
            req_ready_q  <= 1'b1;
            resp_valid_q <= 1'b0;
            resp_err_q   <= 1'b0;
            resp_rdata_q <= '0;
        end else begin
            state_q      <= state_d;
            we_q         <= we_d;
            sgn_q        <= sgn_d;
            size_q       <= size_d;
            off_q        <= off_d;
            wdata_q      <= wdata_d;
            mem_addr_q   <= mem_addr_d;
            mem_din_q    <= mem_din_d;
            cmd_q        <= cmd_d;
            req_ready_q  <= req_ready_d;
            resp_valid_q <= resp_valid_d;
            resp_err_q   <= resp_err_d;
            resp_rdata_q <= resp_rdata_d;
        end
    end

    assign bus.req_ready  = req_ready_q;
    assign bus.resp_valid = resp_valid_q;
    assign bus.resp_err   = resp_err_q;
    assign bus.resp_rdata = resp_rdata_q;
    assign bus.mem_addr   = mem_addr_q;
    assign bus.mem_din    = mem_din_q;
    assign bus.mem_sel    = cmd_q.sel;
    assign bus.mem_str    = cmd_q.str;
    assign bus.mem_ld     = cmd_q.ld;
    assign bus.mem_clr    = cmd_q.clr;

endmodule

// File: tb/tb_mem_access_unit.sv
// Scoreboard bench for mem_access_unit with a behavioural synchronous word memory.
module tb_mem_access_unit;
    import mem_access_pkg::*;

    localparam int unsigned AB = 10;

    typedef struct {
        logic        err;
        logic [31:0] rdata;
        int          lat;
    } exp_t;

    logic clk = 1'b0;
    logic clr_n;
    always #5 clk = ~clk;

    mem_access_unit_if #(.ADDR_BITS(AB)) bus();
    mem_access_unit #(.ADDR_BITS(AB)) dut (.clk(clk), .clr_n(clr_n), .bus(bus));

    exp_t        sb[$];
    int          n_cmp = 0;
    int          n_bad = 0;
    int          cyc = 0;
    int          acc_edge = 0;
    bit          seen = 1'b0;
    logic [31:0] mem [1024];
    int          wr_cnt = 0, rd_cnt = 0, clr_cnt = 0, sel_cnt = 0;
    logic [31:0] last_addr = '0;
    logic [31:0] last_din = '0;

    // Word memory: read data appears the cycle after a read command.
    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (bus.mem_sel) sel_cnt <= sel_cnt + 1;
        if (bus.mem_sel && bus.mem_ld) begin
            bus.mem_dout <= mem[bus.mem_addr];
            rd_cnt       <= rd_cnt + 1;
        end
        if (bus.mem_clr || cyc == 0) begin
            for (int i = 0; i < 1024; i++) mem[i] <= '0;
            if (bus.mem_clr) clr_cnt <= clr_cnt + 1;
        end else if (bus.mem_sel && bus.mem_str) begin
            mem[bus.mem_addr] <= bus.mem_din;
            wr_cnt    <= wr_cnt + 1;
            last_addr <= 32'(bus.mem_addr);
            last_din  <= bus.mem_din;
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic timeout(input string name);
        n_cmp++;
        n_bad++;
        $display("FAIL %s: bound expired at cycle %0d", name, cyc);
    endtask

    // Monitor: compares every presented response against the scoreboard head.
    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            if (!clr_n) begin
                seen = 1'b0;
            end else begin
                if (bus.req_valid && bus.req_ready) acc_edge = cyc + 1;
                if (bus.resp_valid) begin
                    if (sb.size() == 0) begin
                        n_cmp++;
                        n_bad++;
                        $display("FAIL unexpected_resp: got resp_valid=1 rdata %h, expected no response", bus.resp_rdata);
                    end else begin
                        e = sb[0];
                        if (!seen) begin
                            check("latency", 32'(cyc + 1 - acc_edge), 32'(e.lat));
                            seen = 1'b1;
                        end
                        check("resp_rdata", bus.resp_rdata, e.rdata);
                        check("resp_err", 32'(bus.resp_err), 32'(e.err));
                        check("req_ready_in_resp", 32'(bus.req_ready), 32'd0);
                        if (bus.resp_ready) begin
                            void'(sb.pop_front());
                            seen = 1'b0;
                        end
                    end
                end
            end
        end
    end

    task automatic issue(input logic we, input logic [1:0] size, input logic sgn,
                         input logic [AB+1:0] addr, input logic [31:0] wdata, input bit push,
                         input logic err, input logic [31:0] rdata, input int lat);
        exp_t e;
        int   n = 0;
        if (push) begin
            e.err = err; e.rdata = rdata; e.lat = lat;
            sb.push_back(e);
        end
        @(posedge clk); #1;
        bus.req_valid  = 1'b1;
        bus.req_we     = we;
        bus.req_size   = size;
        bus.req_signed = sgn;
        bus.req_addr   = addr;
        bus.req_wdata  = wdata;
        @(negedge clk);
        while (!bus.req_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (n >= 50) timeout("accept");
        @(posedge clk); #1;
        bus.req_valid = 1'b0;
    endtask

    task automatic wait_done();
        int n = 0;
        while ((sb.size() != 0 || !bus.req_ready) && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (n >= 100) begin
            timeout("response");
            sb.delete();
        end
    endtask

    task automatic xfer(input logic we, input logic [1:0] size, input logic sgn,
                        input logic [AB+1:0] addr, input logic [31:0] wdata,
                        input logic err, input logic [31:0] rdata, input int lat);
        issue(we, size, sgn, addr, wdata, 1'b1, err, rdata, lat);
        wait_done();
    endtask

    initial begin : driver
        int w0, r0, s0, c0, n;
        clr_n          = 1'b0;
        bus.req_valid  = 1'b0;
        bus.req_we     = 1'b0;
        bus.req_size   = SZ_WORD;
        bus.req_signed = 1'b0;
        bus.req_addr   = '0;
        bus.req_wdata  = '0;
        bus.flush_req  = 1'b0;
        bus.resp_ready = 1'b1;
        #12;
        check("rst_req_ready", 32'(bus.req_ready), 32'd1);
        check("rst_resp_valid", 32'(bus.resp_valid), 32'd0);
        check("rst_resp_err", 32'(bus.resp_err), 32'd0);
        check("rst_resp_rdata", bus.resp_rdata, 32'd0);
        check("rst_mem_cmd", {28'd0, bus.mem_sel, bus.mem_str, bus.mem_ld, bus.mem_clr}, 32'd0);
        check("rst_mem_addr", 32'(bus.mem_addr), 32'd0);
        check("rst_mem_din", bus.mem_din, 32'd0);
        @(negedge clk);
        clr_n = 1'b1;
        repeat (2) @(negedge clk);

        w0 = wr_cnt; r0 = rd_cnt;
        xfer(1'b1, SZ_WORD, 1'b0, 12'h010, 32'h8899AABB, 1'b0, 32'h0, 2);
        check("sw_write_pulses", 32'(wr_cnt - w0), 32'd1);
        check("sw_read_pulses", 32'(rd_cnt - r0), 32'd0);
        check("sw_mem_addr", last_addr, 32'd4);
        check("sw_mem_din", last_din, 32'h8899AABB);

        xfer(1'b0, SZ_BYTE, 1'b1, 12'h011, '0, 1'b0, 32'hFFFFFF99, 3);
        xfer(1'b0, SZ_BYTE, 1'b0, 12'h011, '0, 1'b0, 32'h00000099, 3);
        xfer(1'b0, SZ_HALF, 1'b1, 12'h010, '0, 1'b0, 32'hFFFF8899, 3);

        // Response held off for 5 cycles; the monitor checks stability every cycle.
        bus.resp_ready = 1'b0;
        issue(1'b0, SZ_HALF, 1'b0, 12'h012, '0, 1'b1, 1'b0, 32'h0000AABB, 3);
        n = 0;
        while (!bus.resp_valid && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (n >= 20) timeout("hold_resp_valid");
        repeat (5) @(negedge clk);
        @(posedge clk); #1;
        bus.resp_ready = 1'b1;
        wait_done();

        w0 = wr_cnt; r0 = rd_cnt;
        xfer(1'b1, SZ_BYTE, 1'b0, 12'h013, 32'h0000005A, 1'b0, 32'h0, 4);
        check("sb_read_pulses", 32'(rd_cnt - r0), 32'd1);
        check("sb_write_pulses", 32'(wr_cnt - w0), 32'd1);
        check("sb_mem_din", last_din, 32'h8899AA5A);
        xfer(1'b0, SZ_WORD, 1'b0, 12'h010, '0, 1'b0, 32'h8899AA5A, 3);

        s0 = sel_cnt;
`ifdef MEM_ACCESS_ALIGN_CHECK_EN
        xfer(1'b0, SZ_WORD, 1'b0, 12'h012, '0, 1'b1, 32'h0, 1);
        check("misaligned_word_no_sel", 32'(sel_cnt - s0), 32'd0);
        xfer(1'b0, SZ_HALF, 1'b0, 12'h011, '0, 1'b1, 32'h0, 1);
`else
        xfer(1'b0, SZ_WORD, 1'b0, 12'h012, '0, 1'b0, 32'h8899AA5A, 3);
        check("forced_word_one_read", 32'(sel_cnt - s0), 32'd1);
        xfer(1'b0, SZ_HALF, 1'b0, 12'h011, '0, 1'b0, 32'h00008899, 3);
`endif
        s0 = sel_cnt;
        xfer(1'b1, SZ_ILL, 1'b0, 12'h010, 32'h12345678, 1'b1, 32'h0, 1);
        check("illegal_size_no_sel", 32'(sel_cnt - s0), 32'd0);

        xfer(1'b1, SZ_HALF, 1'b0, 12'h010, 32'h1234CAFE, 1'b0, 32'h0, 4);
        xfer(1'b0, SZ_WORD, 1'b0, 12'h010, '0, 1'b0, 32'hCAFEAA5A, 3);

        c0 = clr_cnt;
        @(posedge clk); #1;
        bus.flush_req = 1'b1;
        @(posedge clk); #1;
        bus.flush_req = 1'b0;
        repeat (3) @(negedge clk);
        check("flush_clr_pulses", 32'(clr_cnt - c0), 32'd1);
        xfer(1'b0, SZ_WORD, 1'b0, 12'h010, '0, 1'b0, 32'h0, 3);

        // Reset lands in the middle of the write cycle of a sub-word store.
        w0 = wr_cnt;
        issue(1'b1, SZ_BYTE, 1'b0, 12'h014, 32'h00000077, 1'b0, 1'b0, 32'h0, 0);
        n = 0;
        while (!bus.mem_str && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (n >= 20) timeout("reach_write");
        #2 clr_n = 1'b0;
        #1;
        check("mid_rst_resp_valid", 32'(bus.resp_valid), 32'd0);
        check("mid_rst_req_ready", 32'(bus.req_ready), 32'd1);
        check("mid_rst_mem_cmd", {28'd0, bus.mem_sel, bus.mem_str, bus.mem_ld, bus.mem_clr}, 32'd0);
        check("mid_rst_mem_addr", 32'(bus.mem_addr), 32'd0);
        check("mid_rst_mem_din", bus.mem_din, 32'd0);
        @(negedge clk);
        clr_n = 1'b1;
        repeat (6) @(negedge clk);
        check("post_rst_req_ready", 32'(bus.req_ready), 32'd1);
        check("post_rst_no_write", 32'(wr_cnt - w0), 32'd0);
        xfer(1'b0, SZ_WORD, 1'b0, 12'h014, '0, 1'b0, 32'h0, 3);

        repeat (3) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin : watchdog
        #100000;
        $display("FAIL watchdog: simulation did not finish by time %0t", $time);
        $fatal(1, "watchdog");
    end

endmodule
